// File: rtl/debug_unit_pkg.sv
// ---------------------------------------------------------------------------
// debug_unit_pkg
// Shared constants for the pipeline debug unit: the UART command bytes the
// host sends, the controller state encoding, and the byte geometry of a
// dumped word.
// ---------------------------------------------------------------------------
package debug_unit_pkg;

  localparam logic [7:0] CMD_RUN   = 8'h52;
  localparam logic [7:0] CMD_STEP  = 8'h53;
  localparam logic [7:0] CMD_CLEAR = 8'h43;
  localparam logic [7:0] CMD_DUMP  = 8'h44;
  localparam logic [7:0] CMD_PAUSE = 8'h50;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RUN        = 3'd1,
    STEP       = 3'd2,
    CLEAR      = 3'd3,
    DUMP_FETCH = 3'd4,
    DUMP_SEND  = 3'd5
  } state_t;

endpackage

// File: rtl/word_serializer.sv
// ---------------------------------------------------------------------------
// word_serializer
// Takes one NB_WORD-bit word and hands it to the UART transmitter as
// NB_WORD/8 bytes, least significant byte first, over a valid/ready
// handshake. The current byte stays on o_tx_data while the transmitter
// stalls.
//
// Ports:
//   i_clock     clock, rising edge
//   i_reset     synchronous active-low reset
//   i_load      capture i_word and start sending it
//   i_word      word to be serialized
//   i_tx_ready  transmitter accepts the presented byte
//   o_tx_data   byte presented to the transmitter
//   o_tx_valid  o_tx_data is valid
//   o_done      the last byte of the word is being accepted this cycle
// ---------------------------------------------------------------------------
module word_serializer #(
  parameter int NB_WORD = 32
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic [NB_WORD-1:0] i_word,
  input  logic               i_tx_ready,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_valid,
  output logic               o_done
);

  localparam int N_BYTES = NB_WORD / 8;
  localparam int NB_CNT  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [NB_CNT-1:0] LAST_BYTE = NB_CNT'(N_BYTES - 1);

  logic [NB_WORD-1:0] r_shift;
  logic [NB_CNT-1:0]  r_byte_cnt;
  logic               r_busy;
  logic               w_accept;

  assign w_accept   = r_busy & i_tx_ready;
  assign o_done     = w_accept & (r_byte_cnt == LAST_BYTE);
  assign o_tx_data  = r_shift[7:0];
  assign o_tx_valid = r_busy;

  // The low byte of the shift register is always the byte on the wire.
  // An accepted byte shifts the next one down; once the last byte goes the
  // register has shifted to zero, so the idle data lines read 0x00.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_shift    <= '0;
      r_byte_cnt <= '0;
      r_busy     <= 1'b0;
    end else if (i_load) begin
      r_shift    <= i_word;
      r_byte_cnt <= '0;
      r_busy     <= 1'b1;
    end else if (w_accept) begin
      r_shift    <= r_shift >> 8;
      r_byte_cnt <= r_byte_cnt + 1'b1;
      if (r_byte_cnt == LAST_BYTE) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/debug_unit.sv
// ---------------------------------------------------------------------------
// debug_unit
// UART-driven debug controller for the pipeline. Single-byte host commands
// run, single-step, reset or dump the pipeline. A dump streams the cycle
// counter, the PC and N_DUMP_WORDS-2 debug words, each as four bytes LSB
// first.
//
// Ports:
//   i_clock       clock, rising edge
//   i_reset       synchronous active-low reset
//   i_rx_data     command byte from the UART receiver
//   i_rx_valid    i_rx_data valid strobe
//   o_tx_data     byte to the UART transmitter
//   o_tx_valid    o_tx_data valid, held until accepted
//   i_tx_ready    transmitter accepts the byte
//   o_pipe_valid  pipeline clock enable
//   o_pipe_reset  pipeline reset pulse, active high
//   i_pc          current pipeline PC
//   i_halt        pipeline has reached its halt instruction
//   o_dbg_sel     pipeline debug word select
//   i_dbg_data    selected debug word, valid one cycle after o_dbg_sel
// ---------------------------------------------------------------------------
module debug_unit
  import debug_unit_pkg::*;
#(
  parameter int NB_REG       = 32,
  parameter int N_DUMP_WORDS = 34,
  parameter int NB_SEL       = 8
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic              o_pipe_valid,
  output logic              o_pipe_reset,
  input  logic [NB_REG-1:0] i_pc,
  input  logic              i_halt,
  output logic [NB_SEL-1:0] o_dbg_sel,
  input  logic [NB_REG-1:0] i_dbg_data
);

  localparam int NB_IDX = (N_DUMP_WORDS > 1) ? $clog2(N_DUMP_WORDS) : 1;
  localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(N_DUMP_WORDS - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic [NB_REG-1:0]  r_cycle_cnt;
  logic [NB_REG-1:0]  w_cycle_cnt_next;
  logic [NB_IDX-1:0]  r_word_idx;
  logic [NB_IDX-1:0]  w_word_idx_next;
  logic [NB_SEL-1:0]  r_dbg_sel;
  logic [NB_SEL-1:0]  w_dbg_sel_next;
  logic               w_pipe_valid;
  logic               w_pipe_reset;
  logic               w_load;
  logic               w_done;
  logic [NB_REG-1:0]  w_fetch_word;

  // Controller registers. The counter always loads its computed next value,
  // so it is a plain function of the current count and the pipeline enable.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state     <= IDLE;
      r_cycle_cnt <= '0;
      r_word_idx  <= '0;
      r_dbg_sel   <= '0;
    end else begin
      r_state     <= w_next_state;
      r_cycle_cnt <= w_cycle_cnt_next;
      r_word_idx  <= w_word_idx_next;
      r_dbg_sel   <= w_dbg_sel_next;
    end
  end

  // Command decoding and state sequencing. Receive strobes matter only in
  // IDLE (any command) and RUN (pause); elsewhere they are dropped. While
  // word j is fetched the select moves to j-1, so by the fetch of word j+1
  // the debug word (j+1)-2 has been selected for a whole send phase.
  always_comb begin
    w_next_state    = r_state;
    w_pipe_valid    = 1'b0;
    w_pipe_reset    = 1'b0;
    w_load          = 1'b0;
    w_word_idx_next = r_word_idx;
    w_dbg_sel_next  = r_dbg_sel;
    case (r_state)
      IDLE: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_RUN:   w_next_state = RUN;
            CMD_STEP:  w_next_state = STEP;
            CMD_CLEAR: w_next_state = CLEAR;
            CMD_DUMP: begin
              w_next_state    = DUMP_FETCH;
              w_word_idx_next = '0;
            end
            default:   w_next_state = IDLE;
          endcase
        end
      end
      RUN: begin
        w_pipe_valid = ~i_halt;
        if (i_halt) begin
          w_next_state = IDLE;
        end else if (i_rx_valid && (i_rx_data == CMD_PAUSE)) begin
          w_pipe_valid = 1'b0;
          w_next_state = IDLE;
        end
      end
      STEP: begin
        w_pipe_valid = ~i_halt;
        w_next_state = IDLE;
      end
      CLEAR: begin
        w_pipe_reset = 1'b1;
        w_next_state = IDLE;
      end
      DUMP_FETCH: begin
        w_load       = 1'b1;
        w_next_state = DUMP_SEND;
        if (r_word_idx != '0) begin
          w_dbg_sel_next = NB_SEL'(r_word_idx) - NB_SEL'(1);
        end
      end
      DUMP_SEND: begin
        if (w_done) begin
          if (r_word_idx == LAST_IDX) begin
            w_next_state = IDLE;
          end else begin
            w_word_idx_next = r_word_idx + 1'b1;
            w_next_state    = DUMP_FETCH;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Cycle counter: cleared by the clear command, otherwise counts every
  // cycle the pipeline is enabled and wraps naturally at its width.
  always_comb begin
    w_cycle_cnt_next = r_cycle_cnt + NB_REG'(w_pipe_valid);
    if (r_state == CLEAR) begin
      w_cycle_cnt_next = '0;
    end
  end

  // Source of the word being captured: counter, PC, then debug words.
  always_comb begin
    w_fetch_word = i_dbg_data;
    if (r_word_idx == '0) begin
      w_fetch_word = r_cycle_cnt;
    end else if (r_word_idx == NB_IDX'(1)) begin
      w_fetch_word = i_pc;
    end
  end

  // The pipeline controls are also masked by reset so the pipeline stops in
  // the very cycle reset is asserted, not one edge later.
  assign o_pipe_valid = w_pipe_valid & i_reset;
  assign o_pipe_reset = w_pipe_reset & i_reset;
  assign o_dbg_sel    = r_dbg_sel;

  word_serializer #(
    .NB_WORD (NB_REG)
  ) u_word_serializer (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_load     (w_load),
    .i_word     (w_fetch_word),
    .i_tx_ready (i_tx_ready),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .o_done     (w_done)
  );

endmodule

// File: tb/tb_debug_unit.sv
// ---------------------------------------------------------------------------
// tb_debug_unit
// Bench for debug_unit: directed command scenarios followed by random
// command/halt/ready traffic, all compared every cycle against a
// command-level model of the debug unit.
// ---------------------------------------------------------------------------
module tb_debug_unit;

  localparam int NB_REG       = 32;
  localparam int N_DUMP_WORDS = 34;
  localparam int NB_SEL       = 8;
  localparam int DUMP_BYTES   = 4 * N_DUMP_WORDS;

  logic              clock = 1'b0;
  logic              resetN = 1'b0;
  logic [7:0]        rxData = 8'h00;
  logic              rxValid = 1'b0;
  logic [7:0]        txData;
  logic              txValid;
  logic              txReady = 1'b1;
  logic              pipeValid;
  logic              pipeReset;
  logic [NB_REG-1:0] pc = 32'h0040_0010;
  logic              halt = 1'b0;
  logic [NB_SEL-1:0] dbgSel;
  logic [NB_REG-1:0] dbgData = '0;

  int checks = 0;
  int passes = 0;

  bit          mRun = 1'b0;
  bit          mStep = 1'b0;
  bit          mClear = 1'b0;
  logic [7:0]  mTxQ[$];
  logic [31:0] mCnt = '0;
  bit          prevStall = 1'b0;
  logic [7:0]  prevData = '0;
  logic [7:0]  rxLog[$];
  int          pvCount = 0;
  int          prCount = 0;
  int          readyMode = 0;

  logic [7:0]  cmdTab [0:5] = '{8'h52, 8'h53, 8'h43, 8'h44, 8'h50, 8'h41};

  debug_unit #(
    .NB_REG       (NB_REG),
    .N_DUMP_WORDS (N_DUMP_WORDS),
    .NB_SEL       (NB_SEL)
  ) dut (
    .i_clock      (clock),
    .i_reset      (resetN),
    .i_rx_data    (rxData),
    .i_rx_valid   (rxValid),
    .o_tx_data    (txData),
    .o_tx_valid   (txValid),
    .i_tx_ready   (txReady),
    .o_pipe_valid (pipeValid),
    .o_pipe_reset (pipeReset),
    .i_pc         (pc),
    .i_halt       (halt),
    .o_dbg_sel    (dbgSel),
    .i_dbg_data   (dbgData)
  );

  always #5 clock = ~clock;

  // Stand-in for the pipeline debug mux: a recognisable word per select,
  // appearing one cycle after the select.
  function automatic logic [31:0] dbgWord(input logic [7:0] s);
    return {8'hDB, s, ~s, s ^ 8'h3C};
  endfunction

  always @(posedge clock) dbgData <= dbgWord(dbgSel);

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    rxData  = b;
    rxValid = 1'b1;
    tick();
    rxValid = 1'b0;
    rxData  = 8'h00;
  endtask

  task automatic applyReset();
    resetN = 1'b0;
    tick(2);
    resetN = 1'b1;
  endtask

  task automatic waitDumpDone(input int budget);
    int n;
    n = 0;
    while (mTxQ.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checkOutput("dump_done_in_budget", 32'(mTxQ.size()), 0);
  endtask

  function automatic logic [31:0] logWord(input int w);
    if (rxLog.size() < 4 * w + 4) return 32'hBAD0_BAD0;
    return {rxLog[4*w+3], rxLog[4*w+2], rxLog[4*w+1], rxLog[4*w]};
  endfunction

  // Transmitter ready pattern: always ready, alternating, or random.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      case (readyMode)
        1:       txReady = ~txReady;
        2:       txReady = ($urandom_range(0, 3) != 0);
        default: txReady = 1'b1;
      endcase
    end
  end

  // Command-level model and per-cycle compare. A dump command queues every
  // byte the host should receive; the bench only checks that accepted bytes
  // come out in that order, held stable while stalled, and nothing is sent
  // once the queue is drained.
  always @(negedge clock) begin
    logic        expPv;
    logic        idle;
    logic [31:0] w;
    if (!resetN) begin
      checkOutput("pipe_valid_in_reset", 32'(pipeValid), 0);
      mRun = 0;
      mStep = 0;
      mClear = 0;
      mTxQ.delete();
      prevStall = 0;
      mCnt = '0;
    end else begin
      idle  = !mRun && !mStep && !mClear && (mTxQ.size() == 0);
      expPv = 1'b0;
      if (mRun) expPv = !halt && !(rxValid && rxData == 8'h50);
      else if (mStep) expPv = !halt;
      checkOutput("pipe_valid", 32'(pipeValid), 32'(expPv));
      checkOutput("pipe_reset", 32'(pipeReset), 32'(mClear));
      if (pipeValid) pvCount++;
      if (pipeReset) prCount++;
      if (prevStall) begin
        checkOutput("tx_hold_valid", 32'(txValid), 1);
        checkOutput("tx_hold_data", 32'(txData), 32'(prevData));
      end
      if (mTxQ.size() == 0) checkOutput("tx_idle", 32'(txValid), 0);
      else if (txValid && txReady) begin
        checkOutput("tx_byte", 32'(txData), 32'(mTxQ.pop_front()));
        rxLog.push_back(txData);
      end
      prevStall = txValid && !txReady;
      prevData  = txData;
      if (expPv) mCnt = mCnt + 1;
      if (mClear) begin
        mCnt   = '0;
        mClear = 0;
      end
      mStep = 0;
      if (mRun && (halt || (rxValid && rxData == 8'h50))) mRun = 0;
      if (idle && rxValid) begin
        case (rxData)
          8'h52: mRun = 1;
          8'h53: mStep = 1;
          8'h43: mClear = 1;
          8'h44: begin
            for (int k = 0; k < N_DUMP_WORDS; k++) begin
              w = (k == 0) ? mCnt : (k == 1) ? pc : dbgWord(8'(k - 2));
              for (int j = 0; j < 4; j++) mTxQ.push_back(w[8*j +: 8]);
            end
          end
          default: ;
        endcase
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: actual timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tick(1);
    applyReset();
    checkOutput("rst_tx_valid", 32'(txValid), 0);
    checkOutput("rst_tx_data", 32'(txData), 0);
    checkOutput("rst_pipe_valid", 32'(pipeValid), 0);
    checkOutput("rst_pipe_reset", 32'(pipeReset), 0);
    checkOutput("rst_dbg_sel", 32'(dbgSel), 0);

    // Three single steps, then the counter word reads 3.
    pvCount = 0;
    repeat (3) begin
      applyStimulus(8'h53);
      tick();
    end
    checkOutput("step_pv_cycles", pvCount, 3);
    rxLog.delete();
    applyStimulus(8'h44);
    waitDumpDone(2000);
    checkOutput("step_dump_word0", logWord(0), 32'h0000_0003);

    // Run until halt after ten enabled cycles; a stray byte changes nothing.
    pvCount = 0;
    applyStimulus(8'h52);
    tick(10);
    halt = 1'b1;
    tick();
    checkOutput("halt_pv_cycles", pvCount, 10);
    applyStimulus(8'h41);
    halt = 1'b0;
    tick(5);
    checkOutput("idle_after_halt", pvCount, 10);

    // Dump with a transmitter that is ready every other cycle.
    readyMode = 1;
    rxLog.delete();
    applyStimulus(8'h44);
    waitDumpDone(3000);
    readyMode = 0;
    checkOutput("dump_byte_total", 32'(rxLog.size()), DUMP_BYTES);
    checkOutput("dump_pc_word", logWord(1), 32'h0040_0010);
    checkOutput("dump_cnt_word", logWord(0), 32'd13);
    checkOutput("dump_dbg_first", logWord(2), 32'hDB00_FF3C);
    checkOutput("dump_dbg_last", logWord(33), 32'hDB1F_E023);

    // Pause after five cycles, then clear and dump a zero counter.
    pvCount = 0;
    applyStimulus(8'h52);
    tick(5);
    applyStimulus(8'h50);
    checkOutput("pause_pv_cycles", pvCount, 5);
    prCount = 0;
    applyStimulus(8'h43);
    tick();
    checkOutput("clear_pulse_cycles", prCount, 1);
    rxLog.delete();
    applyStimulus(8'h44);
    waitDumpDone(2000);
    checkOutput("clear_dump_word0", logWord(0), 32'h0);

    // Counter at all-ones wraps to zero on one step.
    force dut.r_cycle_cnt = 32'hFFFF_FFFF;
    mCnt = 32'hFFFF_FFFF;
    tick();
    release dut.r_cycle_cnt;
    applyStimulus(8'h53);
    tick();
    rxLog.delete();
    applyStimulus(8'h44);
    waitDumpDone(2000);
    checkOutput("wrap_dump_word0", logWord(0), 32'h0);

    // Reset while the third byte of a dump is on the wire.
    rxLog.delete();
    applyStimulus(8'h44);
    begin
      int n;
      n = 0;
      while (rxLog.size() < 2 && n < 100) begin
        tick();
        n++;
      end
    end
    checkOutput("abort_bytes_seen", 32'(rxLog.size()), 2);
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    checkOutput("abort_tx_valid", 32'(txValid), 0);
    rxLog.delete();
    applyStimulus(8'h44);
    waitDumpDone(2000);
    checkOutput("restart_byte_total", 32'(rxLog.size()), DUMP_BYTES);
    checkOutput("restart_word0", logWord(0), 32'h0);
    checkOutput("restart_word1", logWord(1), 32'h0040_0010);

    // Random traffic against the model.
    readyMode = 2;
    pc = $urandom;
    for (int i = 0; i < 3000; i++) begin
      rxValid = ($urandom_range(0, 7) == 0);
      rxData  = cmdTab[$urandom_range(0, 5)];
      halt    = ($urandom_range(0, 19) == 0);
      resetN  = ($urandom_range(0, 599) != 0);
      tick();
    end
    resetN  = 1'b1;
    rxValid = 1'b0;
    halt    = 1'b0;
    waitDumpDone(3000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
